// File: rtl/multicycle_control_seq_pkg.sv
// multicycle_control_seq_pkg: control state encodings, opcode header constants, trap causes and RF decode
package multicycle_control_seq_pkg;
  typedef enum logic [3:0] {
    CS_IF      = 4'd0,
    CS_RF      = 4'd1,
    CS_IMM3    = 4'd2,
    CS_ALU_R3  = 4'd3,
    CS_ALU_RI3 = 4'd4,
    CS_ALU4    = 4'd5,
    CS_BR3     = 4'd6,
    CS_MEM3    = 4'd7,
    CS_LD4     = 4'd8,
    CS_ST4     = 4'd9,
    CS_LD5     = 4'd10,
    CS_JMP3    = 4'd11,
    CS_HALT    = 4'd12,
    CS_TRAP    = 4'd13
  } cs_t;
  localparam logic [1:0] ALU_R_HEADER      = 2'b00;
  localparam logic [1:0] ALU_RI_HEADER     = 2'b01;
  localparam logic [2:0] BRANCH_HEADER     = 3'b100;
  localparam logic [2:0] MEMORY_REF_HEADER = 3'b101;
  localparam logic [2:0] JUMP_HEADER       = 3'b110;
  localparam logic [5:0] LDI               = 6'b111000;
  localparam logic [5:0] HALT              = 6'b111111;
  localparam logic       LD_BIT            = 1'b0;
  localparam logic       STR_BIT           = 1'b1;
  localparam logic [1:0] TC_NONE           = 2'b00;
  localparam logic [1:0] TC_ILLEGAL        = 2'b01;
  localparam logic [1:0] TC_TIMEOUT        = 2'b10;
  localparam logic [1:0] TC_BAD_STATE      = 2'b11;
  // next state out of RF for the low six opcode bits; unknown 111xxx codes trap
  function automatic cs_t rf_decode(input logic [5:0] op);
    return op[5:4] == ALU_R_HEADER      ? CS_ALU_R3  :
           op[5:4] == ALU_RI_HEADER     ? CS_ALU_RI3 :
           op[5:3] == BRANCH_HEADER     ? CS_BR3     :
           op[5:3] == MEMORY_REF_HEADER ? CS_MEM3    :
           op[5:3] == JUMP_HEADER       ? CS_JMP3    :
           op == LDI                    ? CS_IMM3    :
           op == HALT                   ? CS_HALT    : CS_TRAP;
  endfunction
endpackage

// File: rtl/multicycle_control_seq_ctrl_retire_counter.sv
// ctrl_retire_counter: saturating retired-instruction counter with increment enable
module ctrl_retire_counter #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  output logic [RETIRE_W-1:0] count
);
  // count up on inc, sticking at all-ones
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/multicycle_control_seq.sv
// multicycle_control_seq: multicycle control FSM with memory handshake, traps, HALT and retire count; CTRL_MEM_TIMEOUT_EN adds a memory wait timeout
module multicycle_control_seq
  import multicycle_control_seq_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int RETIRE_W    = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic [3:0]          state,
  output logic                mem_req,
  output logic                retire,
  output logic [RETIRE_W-1:0] retired_count,
  output logic                trap,
  output logic [1:0]          trap_cause
);
  cs_t        cs, nxt;
  logic       hi_bad, timeout, retire_nxt;
  logic [1:0] cause_nxt;
  if (OPCODE_W > 6) begin : g_hi
    assign hi_bad = |opcode[OPCODE_W-1:6];
  end else begin : g_no_hi
    assign hi_bad = 1'b0;
  end
`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  logic [WW-1:0] wait_cnt;
  assign timeout = mem_req && !mem_ready && wait_cnt == WW'(MEM_TIMEOUT - 1);
  // cycles spent waiting on memory in the current state
  always_ff @(posedge clk or negedge reset)
    if (!reset) wait_cnt <= '0;
    else if (nxt != cs) wait_cnt <= '0;
    else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  assign state      = cs;
  assign mem_req    = cs inside {CS_IF, CS_LD4, CS_ST4};
  assign cause_nxt  = cs == CS_RF ? TC_ILLEGAL : mem_req ? TC_TIMEOUT : TC_BAD_STATE;
  assign retire_nxt = (cs inside {CS_IMM3, CS_ALU4, CS_BR3, CS_LD5, CS_JMP3}) ||
                      (cs == CS_ST4 && mem_ready) || (cs == CS_RF && nxt == CS_HALT);
  // state walk; any unlisted code falls into TRAP
  always_comb begin
    nxt = CS_TRAP;
    case (cs)
      CS_IF:                                          nxt = mem_ready ? CS_RF : timeout ? CS_TRAP : CS_IF;
      CS_RF:                                          nxt = hi_bad ? CS_TRAP : rf_decode(opcode[5:0]);
      CS_ALU_R3, CS_ALU_RI3:                          nxt = CS_ALU4;
      CS_MEM3:                                        nxt = opcode[2] == LD_BIT ? CS_LD4 : CS_ST4;
      CS_LD4:                                         nxt = mem_ready ? CS_LD5 : timeout ? CS_TRAP : CS_LD4;
      CS_ST4:                                         nxt = mem_ready ? CS_IF : timeout ? CS_TRAP : CS_ST4;
      CS_IMM3, CS_ALU4, CS_BR3, CS_LD5, CS_JMP3:      nxt = CS_IF;
      CS_HALT:                                        nxt = CS_HALT;
      default:                                        nxt = CS_TRAP;
    endcase
  end
  // state register with registered retire pulse and sticky trap/cause latched on first entry
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cs         <= CS_IF;
      retire     <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= TC_NONE;
    end else begin
      cs     <= nxt;
      retire <= retire_nxt;
      if (nxt == CS_TRAP && !trap) begin
        trap       <= 1'b1;
        trap_cause <= cause_nxt;
      end
    end
  ctrl_retire_counter #(.RETIRE_W(RETIRE_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_nxt),
    .count (retired_count)
  );
endmodule

// File: doc/multicycle_control_seq.md
Name: multicycle_control_seq

Overview:
- Parametrised successor to the multicycle control FSM: same instruction classes and state walk, plus memory-ready handshake on fetch/load/store, illegal-opcode and bad-state trap, a HALT instruction, and a retired-instruction counter.
- Sits between the instruction register (opcode source) and the datapath/memory interface. `state` drives the datapath control decode.

Parameters:
- OPCODE_W, 6, opcode width. Must be ≥6; decode uses bits [5:0], and any nonzero bit above 5 is illegal.
- RETIRE_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum wait cycles without mem_ready before trap. Used only with CTRL_MEM_TIMEOUT_EN; must be ≥1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_W  current instruction opcode, stable from RF onward
- mem_ready  in  1  memory completed the current request this cycle
- state  out  4  current control state
- mem_req  out  1  memory request active (combinational from state)
- retire  out  1  one-cycle pulse when an instruction completes
- retired_count  out  RETIRE_W  saturating count of retired instructions
- trap  out  1  sticky; set in TRAP state
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout, 11 invalid state

Behaviour:
- Reset (reset=0, async): state=IF, retired_count=0, trap=0, trap_cause=00, retire=0, wait counter=0.
- Reset mid-instruction or mid-wait aborts immediately; no retire pulse is produced.
- State encodings: IF=0, RF=1, IMM3=2, ALU_R3=3, ALU_RI3=4, ALU4=5, BR3=6, MEM3=7, LD4=8, ST4=9, LD5=10, JMP3=11, HALT=12, TRAP=13. Codes 14 and 15 are invalid.
- IF: mem_req=1. Go to RF on mem_ready; otherwise hold.
- RF: decode opcode[5:3]:
  - 00x → ALU_R3
  - 01x → ALU_RI3
  - 100 → BR3
  - 101 → MEM3
  - 110 → JMP3
  - 111 with opcode[2:0]=000 → IMM3 (LDI)
  - 111 with opcode[2:0]=111 → HALT
  - 111 with any other opcode[2:0], or any nonzero bit above bit 5 → TRAP, cause 01
- ALU_R3 → ALU4; ALU_RI3 → ALU4.
- MEM3: opcode[2]=0 → LD4; opcode[2]=1 → ST4.
- LD4: mem_req=1. Go to LD5 on mem_ready; otherwise hold.
- ST4: mem_req=1. Go to IF on mem_ready; otherwise hold.
- IMM3, ALU4, BR3, LD5, JMP3 → IF.
- Retire pulse: asserted in the cycle the FSM leaves IMM3, ALU4, BR3, LD5 or JMP3, or leaves ST4 with mem_ready=1. Also asserted once on entry to HALT. retired_count increments on the same edge and saturates at all-ones.
- HALT: holds until reset; mem_req=0.
- TRAP: holds until reset; trap=1. trap_cause is latched on entry and never overwritten.
- Invalid state code (14 or 15): next state TRAP, cause 11.
- Wait counter: clears on every state change and counts cycles spent in IF, LD4 or ST4 while mem_ready=0.
- mem_ready is ignored outside IF, LD4 and ST4.

Optional Feature:
- Macro: CTRL_MEM_TIMEOUT_EN.
- Defined: if the wait counter reaches MEM_TIMEOUT while mem_ready is still 0, next state is TRAP with cause 10. If mem_ready=1 in the same cycle the limit is reached, mem_ready wins and the state advances normally.
- Undefined: no timeout; wait states hold indefinitely; cause 10 is never produced. The wait counter is not synthesised.

Decomposition:
- Shared package holds:
  - state encodings (CS namespace)
  - opcode header constants: ALU_R_HEADER=2'b00, ALU_RI_HEADER=2'b01, BRANCH_HEADER=3'b100, MEMORY_REF_HEADER=3'b101, JUMP=6'b110xxx, LDI=6'b111000, HALT=6'b111111, LD bit2=0, STR bit2=1
  - trap cause codes
- One natural sub-module: ctrl_retire_counter, a saturating counter with increment enable, parametrised by RETIRE_W.

Test Plan:
- ALU R-type, opcode 6'b000010, mem_ready tied 1 → states 0,1,3,5,0; retire pulses once; retired_count=1.
- Load, opcode 6'b101000, mem_ready low for 3 cycles in LD4 → LD4 held 4 cycles, then 10, then 0; retire pulses exactly once.
- Opcode 6'b111010 → state 1 then 13; trap=1, trap_cause=01; stays in 13 for 20 cycles; retire never pulses.
- With CTRL_MEM_TIMEOUT_EN, MEM_TIMEOUT=4, mem_ready=0 in IF → TRAP after 4 wait cycles, cause 10. Without the macro → stays in IF for 100 cycles.
- HALT, opcode 6'b111111 → state 12, one retire pulse. Deassert reset (assert active-low) mid-HALT → state 0, retired_count=0.
- Saturation: RETIRE_W=3, run 9 ALU instructions → retired_count=7.
